// File: rtl/lsu_rmw.sv
// Load/store unit in front of the single-port data memory: word-indexes byte
// addresses, does read-modify-write for SB/SH and formats sub-word load data.
module lsu_rmw #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  logic accept;
  logic req_legal;
  logic req_misaligned;
  logic req_oor;
  logic req_bad;

  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Only the addressed lane of the old word is replaced; the rest is written back.
  function automatic logic [31:0] merge_store(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] old,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = old;
    if (f3[1:0] == 2'b00) begin
      r[{off, 3'b000} +: 8] = wd[7:0];
    end else if (off[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  assign req_ready = (state_q == IDLE) && resetn;
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    req_oor        = 1'b0;
    if (req_we) begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                  (req_funct3 == 3'b010);
    end else begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                  (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                  (req_funct3 == 3'b101);
    end
    if (req_funct3[1:0] == 2'b01) begin
      req_misaligned = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      req_misaligned = (req_addr[1:0] != 2'b00);
    end
    req_oor = ({2'b00, req_addr[31:2]} >= DMEM_LIMIT);
    req_bad = !req_legal || req_misaligned || req_oor;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    old_d     = old_q;
    rdata_d   = rdata_q;
    funct3_d  = funct3_q;
    we_d      = we_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wdata = 32'h0000_0000;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          we_d     = req_we;
          if (req_bad) begin
            rdata_d = 32'h0000_0000;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (!we_q) begin
          rdata_d = format_load(funct3_q, addr_q[1:0], mem_rdata);
          err_d   = 1'b0;
          state_d = RESP;
        end else if (funct3_q[1:0] == 2'b10) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
          rdata_d   = 32'h0000_0000;
          err_d     = 1'b0;
          state_d   = RESP;
        end else begin
          old_d   = mem_rdata;
          state_d = MERGE;
        end
      end

      MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = merge_store(funct3_q, addr_q[1:0], old_q, wdata_q[15:0]);
        rdata_d   = 32'h0000_0000;
        err_d     = 1'b0;
        state_d   = RESP;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      old_q    <= old_d;
      rdata_q  <= rdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = {2'b00, addr_q[31:2]};

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store unit sitting directly upstream of the single-port data memory in the RISC-V core. It accepts one load or store per handshake from the execute stage, converts the byte address to a word index, and drives the memory's word-wide port. It performs read-modify-write for SB/SH, because the memory has no byte enables, and extracts and sign- or zero-extends sub-word load data. Illegal `funct3`, misaligned, and out-of-range accesses are reported as errors and never reach memory.

## Interface
- `DMEM_WORDS`, default 1024: depth of the data memory in 32-bit words; valid word index range is 0..DMEM_WORDS-1.
- `clk`, input, 1: clock.
- `resetn`, input, 1: reset, asynchronous, active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: high only in IDLE with `resetn` high.
- `req_we`, input, 1: 1 = store, 0 = load.
- `req_funct3`, input, 3: RISC-V `funct3` of the load/store instruction.
- `req_addr`, input, 32: byte address.
- `req_wdata`, input, 32: store data; the low byte/half is used for SB/SH.
- `rsp_valid`, output, 1: one-cycle completion pulse; no backpressure.
- `rsp_rdata`, output, 32: formatted load data; 0 for stores and errors.
- `rsp_err`, output, 1: valid with `rsp_valid`; flags illegal `funct3`, misaligned, or out-of-range.
- `mem_addr`, output, 32: word index = `{2'b00, addr[31:2]}` of the latched request.
- `mem_we`, output, 1: memory write strobe; memory writes on the posedge while it is high.
- `mem_wdata`, output, 32: word to write.
- `mem_rdata`, input, 32: combinational read data for `mem_addr`.

## Operation
- The request is latched on `req_valid && req_ready` (`addr`, `we`, `funct3`, `wdata`).
- Loads: `000` LB, `001` LH, `010` LW, `100` LBU, `101` LHU.
- Stores: `000` SB, `001` SH, `010` SW.
- Any other `funct3` sets the error.
- Misaligned: H accesses with `addr[0]=1`, W accesses with `addr[1:0]≠0`.
- Out-of-range: `addr[31:2] >= DMEM_WORDS`.
- Errored requests: go IDLE→RESP; `mem_we` is never asserted.
- States: IDLE, ACCESS, MERGE, RESP.
  - IDLE: accept a request → ACCESS, or → RESP on error.
  - ACCESS, LW/SW: drive `mem_addr`. For a load, latch `mem_rdata`; for SW, `mem_we=1` and `mem_wdata=wdata`. Then → RESP.
  - ACCESS, SB/SH: latch `mem_rdata` as `old` → MERGE.
  - MERGE: `mem_we=1`, and `mem_wdata = old` with the lane at byte offset `addr[1:0]` (SB) or halfword `addr[1]` (SH) replaced by `wdata[7:0]` or `wdata[15:0]` → RESP.
  - RESP: `rsp_valid=1` → IDLE.
- Load formatting:
  - Lane select: byte `addr[1:0]*8`, half `addr[1]*16`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `rsp_rdata` and `rsp_err` are registered and held until the next RESP. Both are 0 after reset.
- `mem_wdata` is 0 whenever `mem_we` is 0.

## Timing
- Request accepted at edge N:
  - LW/LB/LH/LBU/LHU: `rsp_valid` in cycle N+2.
  - SW: write at edge ending cycle N+1; `rsp_valid` in cycle N+2.
  - SB/SH: write at edge ending cycle N+2; `rsp_valid` in cycle N+3.
  - Error: `rsp_valid` in cycle N+1.
- `req_ready` is low from ACCESS through RESP, so there are no back-to-back accepts; the next accept is possible in the cycle after RESP.
- Reset values: `req_ready=0` while `resetn` is low; `rsp_valid`, `rsp_rdata`, `rsp_err`, `mem_addr`, `mem_we`, `mem_wdata` all 0; state IDLE.
- Reset mid-operation: the FSM returns to IDLE immediately and asynchronously, and `mem_we` drops.
  - No partial RMW write and no response are produced for the aborted request.
- `req_*` inputs are ignored outside the accept cycle.
- Changing them after acceptance has no effect.

## Test plan
- Word round trip: SW addr 0x10 data 0xDEADBEEF → `mem_we` pulse at word 4 in cycle N+1, `rsp_valid` at N+2. Then LW 0x10 → `rsp_rdata=0xDEADBEEF`, `rsp_err=0`.
- Byte RMW: word 4 = 0x11223344; SB addr 0x12 data 0xAA → word 4 becomes 0x11AA3344, `rsp_valid` at N+3. Then LB 0x12 → 0xFFFFFFAA; LBU 0x12 → 0x000000AA.
- Half RMW: SH addr 0x16 data 0x8001 into word 5 = 0 → word 5 becomes 0x80010000. LH 0x16 → 0xFFFF8001; LHU → 0x00008001.
- Errors, each giving `rsp_err=1` at N+1, `rsp_rdata=0`, and no `mem_we` pulse:
  - LW addr 0x13;
  - SH addr 0x01;
  - `funct3=011`;
  - SW addr 0x1000 with `DMEM_WORDS=1024`.
- Reset in MERGE: assert `resetn` low during the SB MERGE cycle → `mem_we` drops at once, and no `rsp_valid` after release. After release `req_ready=1`.
- Handshake: hold `req_valid` high continuously with alternating LW/SW → exactly one accept per completed response, `req_ready` low between accept and RESP.
